// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: fetch FSM encoding and default
// reset vector / sequential increment used by the fetch PC unit.
package riscv_pkg;

  localparam int unsigned DEF_XLEN       = 32;
  localparam int unsigned DEF_INC_BY     = 4;
  localparam int unsigned DEF_ALIGN_BITS = 2;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/riscv_align_chk.sv
// Address alignment check, shared between fetch and LSU.
// Ports:
//   addr      - address to test
//   aligned_c - combinational: 1 when the low ALIGN_BITS of addr are zero
module riscv_align_chk
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN       = DEF_XLEN,
  parameter int unsigned ALIGN_BITS = DEF_ALIGN_BITS
) (
  input  logic [XLEN-1:0] addr,
  output logic            aligned_c
);

  // Mask form keeps ALIGN_BITS == 0 legal (always aligned).
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);

  assign aligned_c = ((addr & ALIGN_MASK) == '0);

endmodule

// File: rtl/riscv_fetch_pc.sv
// Fetch program counter with boot cycle, branch/trap redirection and
// misaligned-target fault capture.
// Ports:
//   clk, rst_n          - clock, synchronous active-low reset
//   pc_en               - sequential advance permitted (0 = stall)
//   redirect / _addr    - taken branch/jump and its target
//   trap / trap_vec     - trap request and handler base
//   fetch_ready         - instruction memory accepts pc
//   fetch_valid         - pc is a valid fetch request (RUN only)
//   pc                  - registered fetch address
//   pc_next_seq         - combinational pc + INC_BY (link value)
//   misalign_err        - high while in FAULT
//   fault_addr          - captured misaligned redirect target
module riscv_fetch_pc
  import riscv_pkg::*;
#(
  parameter int unsigned      XLEN         = DEF_XLEN,
  parameter logic [XLEN-1:0]  RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
  parameter int unsigned      INC_BY       = DEF_INC_BY,
  parameter int unsigned      ALIGN_BITS   = DEF_ALIGN_BITS
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pc_en,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_addr,
  input  logic            trap,
  input  logic [XLEN-1:0] trap_vec,
  input  logic            fetch_ready,
  output logic            fetch_valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_next_seq,
  output logic            misalign_err,
  output logic [XLEN-1:0] fault_addr
);

  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);

  fetch_state_e state;
  logic         redirect_aligned;

  riscv_align_chk #(
    .XLEN       (XLEN),
    .ALIGN_BITS (ALIGN_BITS)
  ) u_align_chk (
    .addr      (redirect_addr),
    .aligned_c (redirect_aligned)
  );

  // Wraps modulo 2^XLEN by construction.
  assign pc_next_seq = pc + XLEN'(INC_BY);

  // Fetch FSM and PC update: reset > trap > redirect > sequential > hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_BOOT;
      pc           <= RESET_VECTOR;
      fetch_valid  <= 1'b0;
      misalign_err <= 1'b0;
      fault_addr   <= '0;
    end else if (trap) begin
      // Honoured from every state; handler base is force-aligned.
      state        <= ST_RUN;
      pc           <= trap_vec & ~ALIGN_MASK;
      fetch_valid  <= 1'b1;
      misalign_err <= 1'b0;
    end else begin
      case (state)
        ST_BOOT: begin
          state       <= ST_RUN;
          fetch_valid <= 1'b1;
        end
        ST_RUN: begin
          if (redirect) begin
            if (redirect_aligned) begin
              // Flush: taken regardless of stall or handshake.
              pc <= redirect_addr;
            end else begin
              state        <= ST_FAULT;
              fetch_valid  <= 1'b0;
              misalign_err <= 1'b1;
              fault_addr   <= redirect_addr;
            end
          end else if (pc_en && fetch_ready) begin
            pc <= pc_next_seq;
          end
        end
        ST_FAULT: begin
          // Only trap or reset leave FAULT.
        end
        default: begin
          state       <= ST_BOOT;
          fetch_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_fetch_pc.sv
// Randomized + directed check of riscv_fetch_pc against a rule-level model.
module tb_riscv_fetch_pc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_en;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        trap;
  logic [31:0] trap_vec;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [31:0] pc;
  logic [31:0] pc_next_seq;
  logic        misalign_err;
  logic [31:0] fault_addr;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  // Reference model: architectural view of the fetch unit.
  logic [31:0] m_pc;
  logic [31:0] m_fault_addr;
  bit          m_booting;
  bit          m_faulted;
  bit          m_known = 1'b0;

  riscv_fetch_pc dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_en         (pc_en),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .trap          (trap),
    .trap_vec      (trap_vec),
    .fetch_ready   (fetch_ready),
    .fetch_valid   (fetch_valid),
    .pc            (pc),
    .pc_next_seq   (pc_next_seq),
    .misalign_err  (misalign_err),
    .fault_addr    (fault_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit r, input bit en, input bit rdy,
                       input bit rd, input logic [31:0] ra,
                       input bit tr, input logic [31:0] tv);
    rst_n = r; pc_en = en; fetch_ready = rdy;
    redirect = rd; redirect_addr = ra; trap = tr; trap_vec = tv;
  endtask

  // Apply the architectural rules for one clock edge to the model.
  task automatic model_step();
    if (!rst_n) begin
      m_pc = 32'h0; m_booting = 1'b1; m_faulted = 1'b0; m_fault_addr = 32'h0;
      m_known = 1'b1;
    end else if (trap) begin
      m_pc = {trap_vec[31:2], 2'b00};
      m_booting = 1'b0; m_faulted = 1'b0;
    end else if (m_booting) begin
      m_booting = 1'b0;
    end else if (!m_faulted) begin
      if (redirect) begin
        if (redirect_addr[1:0] == 2'b00) m_pc = redirect_addr;
        else begin m_faulted = 1'b1; m_fault_addr = redirect_addr; end
      end else if (pc_en && fetch_ready) begin
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  // One clock: check link value pre-edge, advance model, compare post-edge.
  task automatic tick();
    if (m_known) check("pc_next_seq", pc_next_seq, m_pc + 32'd4);
    model_step();
    @(posedge clk);
    #1;
    check("pc", pc, m_pc);
    check("fetch_valid", 32'(fetch_valid), 32'(!m_booting && !m_faulted));
    check("misalign_err", 32'(misalign_err), 32'(m_faulted));
    check("fault_addr", fault_addr, m_fault_addr);
  endtask

  initial begin
    drive(0, 0, 0, 0, 32'h0, 0, 32'h0);
    @(negedge clk);
    tick(); tick();
    check("rst_pc", pc, 32'h0);
    check("rst_valid", 32'(fetch_valid), 32'h0);

    // Boot sequence: one invalid cycle at 0, then 0, 4, 8.
    drive(1, 1, 1, 0, 32'h0, 0, 32'h0);
    check("boot_valid", 32'(fetch_valid), 32'h0);
    tick(); check("seq0", pc, 32'h0); check("seq0_valid", 32'(fetch_valid), 32'h1);
    tick(); check("seq1", pc, 32'h4);
    tick(); check("seq2", pc, 32'h8);

    // Aligned redirect with fetch_ready low still flushes.
    drive(1, 1, 1, 0, 32'h0, 1, 32'h10); tick();
    drive(1, 1, 0, 1, 32'h100, 0, 32'h0); tick();
    check("redir_flush", pc, 32'h100);

    // Misaligned redirect -> FAULT; FAULT ignores redirect/pc_en; trap exits.
    drive(1, 1, 1, 1, 32'h102, 0, 32'h0); tick();
    check("fault_pc", pc, 32'h100);
    check("fault_err", 32'(misalign_err), 32'h1);
    check("fault_addr", fault_addr, 32'h102);
    drive(1, 1, 1, 1, 32'h40, 0, 32'h0); tick();
    check("fault_hold", pc, 32'h100);
    drive(1, 1, 1, 0, 32'h0, 1, 32'h203); tick();
    check("trap_exit_pc", pc, 32'h200);
    check("trap_exit_err", 32'(misalign_err), 32'h0);
    check("trap_exit_valid", 32'(fetch_valid), 32'h1);

    // Trap beats redirect.
    drive(1, 1, 1, 1, 32'h40, 1, 32'h80); tick();
    check("trap_prio", pc, 32'h80);

    // Wrap at top of address space.
    drive(1, 1, 1, 0, 32'h0, 1, 32'hFFFF_FFFC); tick();
    drive(1, 1, 1, 0, 32'h0, 0, 32'h0);
    check("wrap_link", pc_next_seq, 32'h0);
    tick(); check("wrap_pc", pc, 32'h0);

    // Stall then reset mid-stall.
    drive(1, 1, 1, 0, 32'h0, 1, 32'h20); tick();
    drive(1, 0, 1, 0, 32'h0, 0, 32'h0);
    for (int i = 0; i < 3; i++) begin tick(); check("stall", pc, 32'h20); end
    drive(0, 0, 1, 1, 32'h44, 1, 32'h88); tick();
    check("mid_stall_rst_pc", pc, 32'h0);
    check("mid_stall_rst_valid", 32'(fetch_valid), 32'h0);

    // Redirect ignored in BOOT, trap honoured in BOOT.
    drive(1, 1, 1, 1, 32'h44, 0, 32'h0); tick();
    check("boot_redir_ignored", pc, 32'h0);
    drive(0, 0, 0, 0, 32'h0, 0, 32'h0); tick();
    drive(1, 1, 1, 0, 32'h0, 1, 32'h55); tick();
    check("boot_trap", pc, 32'h54);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] ra;
      ra = $urandom();
      if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
      drive($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0, ra,
            $urandom_range(0, 19) == 0, $urandom());
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
